// File: rtl/add_tree_pkg.sv
// Shared helpers for the add_tree_sat adder tree: width derivation,
// per-level operand counts and output saturation limits.
package add_tree_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = 1; v < value; v = v << 1) r++;
    return r;
  endfunction

  // Internal width: one bit for exact negation of the most negative operand,
  // plus one growth bit per tree level.
  function automatic int calc_iw(input int w, input int n);
    return w + 1 + clog2(n);
  endfunction

  // Number of operands entering tree level lvl (level 0 sees all N).
  // Odd counts pass their last operand straight through, which is the same
  // as padding the tree with zero operands.
  function automatic int level_ops(input int n, input int lvl);
    int m;
    m = n;
    for (int i = 0; i < lvl; i++) m = (m + 1) / 2;
    return m;
  endfunction

  // Largest representable OUT_W-bit signed value.
  function automatic longint sat_hi(input int out_w);
    return (longint'(1) << (out_w - 1)) - 1;
  endfunction

  // Smallest representable OUT_W-bit signed value.
  function automatic longint sat_lo(input int out_w);
    return -(longint'(1) << (out_w - 1));
  endfunction

endpackage

// File: rtl/add_tree_level.sv
// One registered level of the adder tree: M inputs are added pairwise into
// ceil(M/2) outputs at full width IW. An unpaired last input passes through.
module add_tree_level #(
  parameter int M  = 4,
  parameter int IW = 19
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ce,
  input  logic [M*IW-1:0]             d,
  output logic [((M+1)/2)*IW-1:0]     q
);

  localparam int MO = (M + 1) / 2;

  logic [MO*IW-1:0] sum;

  // Pairwise adders; IW already carries the growth so no carry is lost.
  for (genvar j = 0; j < MO; j++) begin : g_pair
    if (2 * j + 1 < M) begin : g_add
      assign sum[j*IW +: IW] = d[2*j*IW +: IW] + d[(2*j+1)*IW +: IW];
    end else begin : g_pass
      assign sum[j*IW +: IW] = d[2*j*IW +: IW];
    end
  end

  // Level register: synchronous reset wins over ce, ce=0 holds.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the tree levels shift coherently.
    if (!rst_n) begin
      q <= '0;
    end else if (ce) begin
      q <= sum;
    end
  end

endmodule

// File: rtl/add_tree_sat.sv
// add_tree_sat: pipelined N-operand signed adder/subtractor.
// Operand k is in_data[k*W +: W], subtracted when sub_mask[k] is set.
// Latency is clog2(N)+1 enabled cycles; ce=0 freezes the whole pipe.
// Build option ADD_TREE_SAT_EN: saturating output stage; when undefined the
// output wraps to the low OUT_W bits. out_ovf reports overflow either way.
module add_tree_sat
  import add_tree_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int OUT_W = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               in_valid,
  input  logic [N*W-1:0]     in_data,
  input  logic [N-1:0]       sub_mask,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_sum,
  output logic               out_ovf
);

  localparam int LEV = clog2(N);
  localparam int L   = LEV + 1;
  localparam int IW  = calc_iw(W, N);
  localparam int GW  = IW - W - 1;

  localparam logic signed [IW-1:0] SAT_HI = IW'(sat_hi(OUT_W));
  localparam logic signed [IW-1:0] SAT_LO = IW'(sat_lo(OUT_W));

  logic [N*IW-1:0]         cond;
  logic signed [IW-1:0]    tree_sum;
  logic [OUT_W-1:0]        sum_c;
  logic                    ovf_c;
  logic [L-1:0]            vpipe;

  // Input conditioning: sign-extend to W+1 bits so negating -2^(W-1) is
  // exact, optionally negate, then sign-extend to the tree width.
  always_comb begin
    logic signed [W:0] ext;
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cond = '0;
    ext  = '0;
    for (int k = 0; k < N; k++) begin
      ext = {in_data[k*W+W-1], in_data[k*W +: W]};
      if (sub_mask[k]) ext = -ext;
      cond[k*IW +: IW] = {{GW{ext[W]}}, ext};
    end
  end

  // Adder tree: clog2(N) registered levels, each halving the operand count.
  for (genvar g = 0; g < LEV; g++) begin : g_lvl
    localparam int MI = level_ops(N, g);
    localparam int MO = level_ops(N, g + 1);
    logic [MO*IW-1:0] q;
    if (g == 0) begin : g_first
      add_tree_level #(.M(MI), .IW(IW)) u_level (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .d     (cond),
        .q     (q)
      );
    end else begin : g_next
      add_tree_level #(.M(MI), .IW(IW)) u_level (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .d     (g_lvl[g-1].q),
        .q     (q)
      );
    end
  end

  assign tree_sum = g_lvl[LEV-1].q;

  // Output reduction: one shared range comparison drives both the overflow
  // flag and (when saturating) the clamp select.
  always_comb begin
    ovf_c = (tree_sum > SAT_HI) || (tree_sum < SAT_LO);
`ifdef ADD_TREE_SAT_EN
    if (ovf_c) begin
      sum_c = tree_sum[IW-1] ? SAT_LO[OUT_W-1:0] : SAT_HI[OUT_W-1:0];
    end else begin
      sum_c = tree_sum[OUT_W-1:0];
    end
`else
    sum_c = tree_sum[OUT_W-1:0];
`endif
  end

  // Output register and valid shift register, frozen together by ce.
  always_ff @(posedge clk) begin
    // NOTE: data registers are reset too, so a reset drains in-flight beats
    // and out_sum reads 0 rather than stale data right after reset.
    if (!rst_n) begin
      out_sum <= '0;
      out_ovf <= 1'b0;
      vpipe   <= '0;
    end else if (ce) begin
      out_sum <= sum_c;
      out_ovf <= ovf_c;
      vpipe   <= {vpipe[L-2:0], in_valid};
    end
  end

  assign out_valid = vpipe[L-1];

endmodule

// File: tb/tb_add_tree_sat.sv
// Self-checking bench for add_tree_sat (defaults N=4, W=16, OUT_W=18), plus
// an N=3 instance and an OUT_W=17 instance for the padding and narrow-output
// cases. Expected results follow the ADD_TREE_SAT_EN build option.
module tb_add_tree_sat;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int OUT_W = 18;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ce;
  logic               in_valid;
  logic [N*W-1:0]     in_data;
  logic [N-1:0]       sub_mask;
  logic               out_valid;
  logic [OUT_W-1:0]   out_sum;
  logic               out_ovf;

  logic               v3;
  logic [3*W-1:0]     d3;
  logic [2:0]         m3;
  logic               ov3;
  logic [OUT_W-1:0]   s3;
  logic               f3;

  logic               v17;
  logic [N*W-1:0]     d17;
  logic [N-1:0]       m17;
  logic               ov17;
  logic [16:0]        s17;
  logic               f17;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  typedef struct packed {
    logic [OUT_W-1:0] sum;
    logic             ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  add_tree_sat #(.N(N), .W(W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_data(in_data),
    .sub_mask(sub_mask), .out_valid(out_valid), .out_sum(out_sum), .out_ovf(out_ovf)
  );

  add_tree_sat #(.N(3), .W(W), .OUT_W(OUT_W)) dut_n3 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(v3), .in_data(d3),
    .sub_mask(m3), .out_valid(ov3), .out_sum(s3), .out_ovf(f3)
  );

  add_tree_sat #(.N(N), .W(W), .OUT_W(17)) dut_w17 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(v17), .in_data(d17),
    .sub_mask(m17), .out_valid(ov17), .out_sum(s17), .out_ovf(f17)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: exact integer sum, then clamp or wrap to OUT_W.
  function automatic exp_t model(input logic [N*W-1:0] d, input logic [N-1:0] m);
    longint acc;
    longint op;
    longint lo;
    longint hi;
    exp_t   e;
    acc = 0;
    lo  = -(longint'(1) << (OUT_W - 1));
    hi  = -lo - 1;
    for (int k = 0; k < N; k++) begin
      op  = longint'($signed(d[k*W +: W]));
      acc = m[k] ? acc - op : acc + op;
    end
    e.ovf = (acc > hi) || (acc < lo);
`ifdef ADD_TREE_SAT_EN
    if (acc > hi) acc = hi;
    else if (acc < lo) acc = lo;
`endif
    e.sum = acc[OUT_W-1:0];
    return e;
  endfunction

  function automatic logic [N*W-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [W-1:0] a_w, b_w, c_w, d_w;
    a_w = W'(a);
    b_w = W'(b);
    c_w = W'(c);
    d_w = W'(d);
    return {d_w, c_w, b_w, a_w};
  endfunction

  function automatic logic [N*W-1:0] rnd_data();
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'($urandom);
    return r;
  endfunction

  // Drive one cycle of stimulus; an accepted beat pushes its expectation.
  task automatic drive(input logic v, input logic [N*W-1:0] d, input logic [N-1:0] m,
                       input logic c);
    in_valid = v;
    in_data  = d;
    sub_mask = m;
    ce       = c;
    if (v && c && rst_n) sb.push_back(model(d, m));
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a new result appears only after an enabled edge.
  logic en_s = 1'b0;
  always @(posedge clk) en_s <= ce && rst_n;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && en_s && out_valid) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow observed=extra_output expected=no_output");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_sum", 32'(out_sum), 32'(e.sum));
        check("sb_ovf", 32'(out_ovf), 32'(e.ovf));
        n_out++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=hung expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [OUT_W-1:0] hold_sum;
    logic             hold_valid;
    logic [W-1:0]     p0, p1, p2;
    int               n0;

    rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; in_data = '0; sub_mask = '0;
    v3 = 1'b0; d3 = '0; m3 = '0; v17 = 1'b0; d17 = '0; m17 = '0;

    // Reset state.
    drive(0, pack4(3, 3, 3, 3), '0, 1);
    drive(0, pack4(3, 3, 3, 3), '0, 1);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_sum", 32'(out_sum), 0);
    check("rst_ovf", 32'(out_ovf), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, '0, 1);
      check("post_rst_idle", 32'(out_valid), 0);
    end

    // Add only, with exact latency check.
    drive(1, pack4(100, 200, -50, 7), 4'b0000, 1);
    check("lat_1", 32'(out_valid), 0);
    drive(0, '0, '0, 1);
    check("lat_2", 32'(out_valid), 0);
    drive(0, '0, '0, 1);
    check("lat_3", 32'(out_valid), 1);
    check("add_sum", 32'(out_sum), 257);
    check("add_ovf", 32'(out_ovf), 0);
    drive(0, '0, '0, 1);

    // Error form and extreme values, back to back.
    drive(1, pack4(1000, 400, 0, 0), 4'b0010, 1);
    drive(1, pack4(-32768, -32768, -32768, -32768), 4'b1111, 1);
    drive(1, pack4(-32768, -32768, -32768, -32768), 4'b0000, 1);
    check("err_sum", 32'(out_sum), 600);
    check("err_valid", 32'(out_valid), 1);
    drive(0, '0, '0, 1);
`ifdef ADD_TREE_SAT_EN
    check("pos_ovf_sum", 32'(out_sum), 32'h1FFFF);
`else
    check("pos_ovf_sum", 32'(out_sum), 32'h20000);
`endif
    check("pos_ovf_flag", 32'(out_ovf), 1);
    drive(0, '0, '0, 1);
    check("neg_fit_sum", 32'(out_sum), 32'h20000);
    check("neg_fit_flag", 32'(out_ovf), 0);
    drive(0, '0, '0, 1);
    drive(0, '0, '0, 1);
    check("drain_valid", 32'(out_valid), 0);

    // Streaming 10 beats with a 2-cycle stall mid-stream.
    n0 = n_out;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        hold_sum   = out_sum;
        hold_valid = out_valid;
        check("stall_pre_valid", 32'(hold_valid), 1);
        for (int s = 0; s < 2; s++) begin
          drive(1, rnd_data(), 4'b1111, 0);
          check("stall_sum", 32'(out_sum), 32'(hold_sum));
          check("stall_valid", 32'(out_valid), 32'(hold_valid));
        end
      end
      drive(1, rnd_data(), N'($urandom), 1);
    end
    for (int i = 0; i < 4; i++) drive(0, '0, '0, 1);
    check("stream_count", 32'(n_out - n0), 10);
    check("stream_sb_empty", 32'(sb.size()), 0);

    // Reset with two beats in flight.
    drive(1, pack4(1000, 2000, 3000, 4000), 4'b0000, 1);
    drive(1, pack4(-5, -6, -7, -8), 4'b0000, 1);
    rst_n = 1'b0;
    sb.delete();
    drive(0, '0, '0, 1);
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_sum", 32'(out_sum), 0);
    check("midrst_ovf", 32'(out_ovf), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(0, pack4(1, 1, 1, 1), '0, 1);
      check("midrst_no_stale", 32'(out_valid), 0);
    end

    // N=3 padding and OUT_W=17 negative overflow.
    p0 = W'(5);
    p1 = W'(-9);
    p2 = W'(4);
    d3  = {p2, p1, p0};
    m3  = 3'b000;
    v3  = 1'b1;
    d17 = pack4(-32768, -32768, -32768, -32768);
    m17 = '0;
    v17 = 1'b1;
    drive(0, '0, '0, 1);
    v3  = 1'b0;
    v17 = 1'b0;
    d3  = {W'(7), W'(7), W'(7)};
    d17 = pack4(9, 9, 9, 9);
    drive(0, '0, '0, 1);
    check("n3_lat_2", 32'(ov3), 0);
    check("w17_lat_2", 32'(ov17), 0);
    drive(0, '0, '0, 1);
    check("n3_valid", 32'(ov3), 1);
    check("n3_sum", 32'(s3), 0);
    check("n3_ovf", 32'(f3), 0);
    check("w17_valid", 32'(ov17), 1);
`ifdef ADD_TREE_SAT_EN
    check("w17_sum", 32'(s17), 32'h10000);
`else
    check("w17_sum", 32'(s17), 32'h00000);
`endif
    check("w17_ovf", 32'(f17), 1);
    drive(0, '0, '0, 1);
    check("n3_next_sum", 32'(s3), 21);
    check("final_sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_tree_sat.md
# add_tree_sat

Parametrised, pipelined multi-operand signed adder/subtractor with optional output saturation. It is the general form of the registered two-input adder in the PID datapath. It takes N signed operands per beat, each optionally negated by a per-operand mask, and produces their registered sum at a fixed latency with valid tracking and a pipeline stall. It sits between the error/term generators and the PID output stage, where it forms the error (r − y) and sums the P/I/D terms.

## Interface
Parameters:
- N, 4, operand count; 2..8, and non-power-of-2 values are padded with zero operands.
- W, 16, operand width, signed two's complement.
- OUT_W, 18, output width; must satisfy 2 ≤ OUT_W ≤ IW.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  reset; synchronous and active-low.
- ce  in  1  pipeline enable; 0 freezes every register.
- in_valid  in  1  beat qualifier for in_data/sub_mask.
- in_data  in  N*W  packed operands; operand k is in_data[k*W +: W].
- sub_mask  in  N  bit k=1 subtracts operand k, bit k=0 adds it.
- out_valid  out  1  out_sum/out_ovf hold a result.
- out_sum  out  OUT_W  signed sum.
- out_ovf  out  1  true sum fell outside the OUT_W range.

## Operation
- Internal width IW = W + 1 + clog2(N). For the defaults, IW = 19.
- Input conditioning is combinational:
  - sign-extend each operand to W+1 bits;
  - negate it when its sub_mask bit is set;
  - the extension makes −(−2^(W−1)) exact (+32768 at W=16).
- The adder tree has clog2(N) levels. Each level adds pairs at full width and is registered.
- The output stage is registered and reduces IW bits to OUT_W bits:
  - With ADD_TREE_SAT_EN, clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - Without it, keep the low OUT_W bits (wrap).
- out_ovf is set when the IW-bit sum is outside the OUT_W range, regardless of mode.
- in_valid travels down a shift register of latency length, alongside the data.
- When in_valid is 0, data registers still load. The output value is don't-care; consumers qualify it with out_valid.
- Reset (rst_n=0 at a clock edge):
  - every pipeline register, out_sum, out_ovf and out_valid go to 0;
  - reset overrides ce;
  - beats in flight are discarded, and no valid output appears until a new beat has traversed the full latency after release.

## Timing
- Latency L = clog2(N) + 1 enabled cycles from an in_valid beat to out_valid. Defaults (N=4): L = 3. N=2: L = 2.
- Throughput is one beat per cycle while ce=1.
- ce=0:
  - all stages, including the valid pipe, hold their values;
  - the inputs are ignored that cycle;
  - out_valid stays asserted if it was asserted, so a result is not lost or duplicated in the sense of new data, but it remains visible while held.
- ce and rst_n are sampled at the same edge. rst_n=0 wins.
- Back-to-back beats produce back-to-back outputs in order. No bubbles are inserted.
- After reset release, out_valid is 0 for at least L cycles.

## Configuration
- Macro ADD_TREE_SAT_EN.
- Defined: saturating output stage. A positive overflow gives 2^(OUT_W−1)−1; a negative overflow gives −2^(OUT_W−1).
- Undefined: wrapping output stage (truncation of the low OUT_W bits). out_ovf still reports overflow, and the comparison logic is shared.

## Structure
- Shared package add_tree_pkg holds:
  - clog2 constant function;
  - IW derivation function;
  - saturation-limit constants as functions of OUT_W.
- Sub-module add_tree_level: one registered level that adds M inputs pairwise into ceil(M/2) outputs at width IW, with ce and synchronous reset. It is instantiated clog2(N) times via generate.
- The top contains:
  - input conditioning;
  - valid shift register;
  - output saturate/wrap stage.

## Test plan
Defaults are N=4, W=16, OUT_W=18, L=3 unless stated.
- Add only: operands {100, 200, −50, 7}, mask 0000 → out_sum=257, out_ovf=0, out_valid exactly 3 cycles after in_valid.
- Error form: operands {1000, 400, 0, 0}, mask 0010 → 600. All four operands = −32768, mask 1111 → +131072, out_ovf=1. With ADD_TREE_SAT_EN, out_sum=131071; without it, out_sum=−131072.
- Negative saturation: all operands = −32768, mask 0000 → −131072, which fits exactly, so out_ovf=0. At OUT_W=17, the same input gives −65536 with out_ovf=1.
- Streaming with stall: 10 consecutive beats, with ce=0 held for 2 cycles mid-stream → 10 outputs in order, none dropped or duplicated, output frozen during the stall.
- Reset mid-flight: rst_n=0 for 1 cycle with 2 beats in flight → out_valid=0 and out_sum=0 next cycle, and no stale beat emerges afterwards.
- N=3 padding: operands {5, −9, 4}, mask 000 → 0 at L=3.
